// File: rtl/iomem_ctrl_if.sv
// Bus bundle between the PicoSoC iomem port and the peripheral slots.
// The 'slave' modport is the controller's view; 'master' is the core/peripheral side.
interface iomem_ctrl_if #(
  parameter int unsigned NSLOTS = 4
);
  logic                     iomem_valid;
  logic                     iomem_ready;
  logic [3:0]               iomem_wstrb;
  logic [31:0]              iomem_addr;
  logic [31:0]              iomem_wdata;
  logic [31:0]              iomem_rdata;
  logic [NSLOTS-1:0]        slv_valid;
  logic [NSLOTS-1:0]        slv_ready;
  logic [32*NSLOTS-1:0]     slv_rdata;
  logic [31:0]              slv_addr;
  logic [3:0]               slv_wstrb;
  logic [31:0]              slv_wdata;

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, slv_ready, slv_rdata,
    output iomem_ready, iomem_rdata, slv_valid, slv_addr, slv_wstrb, slv_wdata
  );

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, slv_ready, slv_rdata,
    input  iomem_ready, iomem_rdata, slv_valid, slv_addr, slv_wstrb, slv_wdata
  );
endinterface

// File: rtl/iomem_ctrl.sv
// iomem sequencer/page decoder: one 16 MiB page per slot, unmapped pages answer 32'hFFFF_FFFF.
// Optional hung-access timeout is enabled by defining IOMEM_CTRL_TIMEOUT_EN.
module iomem_ctrl #(
  parameter int unsigned NSLOTS    = 4,
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          resetn,
  iomem_ctrl_if.slave   bus,
  output logic          err_irq
);

  if (NSLOTS < 1 || NSLOTS > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("iomem_ctrl: NSLOTS must be 1..8 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                ready_d;
  logic [31:0]         rdata_d;
  logic [NSLOTS-1:0]   valid_d;
  logic [31:0]         addr_d;
  logic [3:0]          wstrb_d;
  logic [31:0]         wdata_d;
  logic [7:0]          page_off;
  logic                sel_hit;
  logic [31:0]         sel_data;

  assign page_off = bus.iomem_addr[31:24] - BASE_PAGE;
  // slv_valid is one-hot and held through ACCESS, so it doubles as the slot select
  assign sel_hit  = |(bus.slv_ready & bus.slv_valid);

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NSLOTS; i++)
      if (bus.slv_valid[i]) sel_data = sel_data | bus.slv_rdata[32*i +: 32];
  end

`ifdef IOMEM_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_d;
`endif

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    rdata_d = bus.iomem_rdata;
    valid_d = bus.slv_valid;
    addr_d  = bus.slv_addr;
    wstrb_d = bus.slv_wstrb;
    wdata_d = bus.slv_wdata;
`ifdef IOMEM_CTRL_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.iomem_valid && !bus.iomem_ready) begin
          addr_d  = bus.iomem_addr;
          wstrb_d = bus.iomem_wstrb;
          wdata_d = bus.iomem_wdata;
          if (page_off < 8'(NSLOTS)) begin
            for (int unsigned i = 0; i < NSLOTS; i++)
              valid_d[i] = (page_off == 8'(i));
            state_d = ACCESS;
`ifdef IOMEM_CTRL_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rdata_d = '1;
            ready_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_hit) begin
          rdata_d = sel_data;
          valid_d = '0;
          ready_d = 1'b1;
          state_d = RESP;
        end
`ifdef IOMEM_CTRL_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rdata_d = 32'hDEAD_BEEF;
          valid_d = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      bus.slv_valid   <= '0;
      bus.slv_addr    <= '0;
      bus.slv_wstrb   <= '0;
      bus.slv_wdata   <= '0;
    end else begin
      state_q         <= state_d;
      bus.iomem_ready <= ready_d;
      bus.iomem_rdata <= rdata_d;
      bus.slv_valid   <= valid_d;
      bus.slv_addr    <= addr_d;
      bus.slv_wstrb   <= wstrb_d;
      bus.slv_wdata   <= wdata_d;
    end
  end

`ifdef IOMEM_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      err_irq <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      err_irq <= err_d;
    end
  end
`else
  assign err_irq = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_ctrl.sv
// Randomized bench for iomem_ctrl: a transaction-level model predicts the completion
// cycle, read data and error pulse of each request from the address map and slave latency.
module tb_iomem_ctrl;
  localparam int unsigned NSLOTS    = 4;
  localparam logic [7:0]  BASE_PAGE = 8'h03;
  localparam int unsigned TIMEOUT   = 8;
`ifdef IOMEM_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic err_irq;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  iomem_ctrl_if #(.NSLOTS(NSLOTS)) bus ();

  iomem_ctrl #(
    .NSLOTS   (NSLOTS),
    .BASE_PAGE(BASE_PAGE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One core request plus the addressed slave, which raises ready 'lat' cycles after
  // it first sees its valid. Unselected slots toggle random ready bits throughout.
  task automatic txn(input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input int unsigned lat, input bit hold);
    logic [7:0]        off;
    bit                mapped;
    int unsigned       slot;
    int unsigned       exp_cyc;
    logic [31:0]       exp_rdata;
    logic              exp_err;
    logic [NSLOTS-1:0] onehot;
    logic [31:0]       rd [NSLOTS];
    int unsigned       vseen;

    off    = addr[31:24] - BASE_PAGE;
    mapped = (int'(off) < int'(NSLOTS));
    slot   = int'(off);
    onehot = '0;
    if (mapped) onehot[slot] = 1'b1;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      rd[i] = $urandom;
      bus.slv_rdata[32*i +: 32] = rd[i];
    end

    exp_err = 1'b0;
    if (!mapped) begin
      exp_cyc   = 1;
      exp_rdata = 32'hFFFF_FFFF;
    end else if (TO_EN && lat + 1 > TIMEOUT) begin
      exp_cyc   = TIMEOUT + 1;
      exp_rdata = 32'hDEAD_BEEF;
      exp_err   = 1'b1;
    end else begin
      exp_cyc   = lat + 2;
      exp_rdata = rd[slot];
    end

    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    bus.slv_ready   = '0;
    vseen = 0;
    @(posedge clk); #1;
    for (int unsigned c = 1; c <= exp_cyc + 1; c++) begin
      check("iomem_ready", {31'b0, bus.iomem_ready}, {31'b0, c == exp_cyc});
      check("err_irq", {31'b0, err_irq}, {31'b0, (c == exp_cyc) && exp_err});
      if (c == exp_cyc) check("iomem_rdata", bus.iomem_rdata, exp_rdata);
      check("slv_valid", 32'(bus.slv_valid), (mapped && c < exp_cyc) ? 32'(onehot) : 32'd0);
      if (mapped && c == 1) begin
        check("slv_addr", bus.slv_addr, addr);
        check("slv_wstrb", {28'b0, bus.slv_wstrb}, {28'b0, wstrb});
        check("slv_wdata", bus.slv_wdata, wdata);
      end
      if (!hold || c >= exp_cyc) bus.iomem_valid = 1'b0;
      if ((bus.slv_valid & onehot) != '0) vseen++;
      bus.slv_ready = NSLOTS'($urandom) & ~onehot;
      if (mapped && (bus.slv_valid & onehot) != '0 && vseen > lat) bus.slv_ready = bus.slv_ready | onehot;
      @(posedge clk); #1;
    end
    bus.slv_ready   = '0;
    bus.iomem_valid = 1'b0;
  endtask

  initial begin
    resetn          = 1'b0;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = '0;
    bus.iomem_wstrb = '0;
    bus.iomem_wdata = '0;
    bus.slv_ready   = '0;
    bus.slv_rdata   = '0;
    #23;
    check("rst iomem_ready", {31'b0, bus.iomem_ready}, 32'd0);
    check("rst iomem_rdata", bus.iomem_rdata, 32'd0);
    check("rst slv_valid", 32'(bus.slv_valid), 32'd0);
    check("rst err_irq", {31'b0, err_irq}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    txn(32'h0300_0000, 4'hF, 32'h0000_00A5, 1, 1'b1);
    txn(32'h0500_0000, 4'h0, 32'h0, 1, 1'b1);
    txn(32'h0500_0000, 4'h0, 32'h0, 4, 1'b0);
    txn(32'h0700_0000, 4'hF, 32'hCAFE_0001, 1, 1'b1);
    txn(32'h0200_0010, 4'h0, 32'h0, 1, 1'b1);
    txn(32'h0400_0000, 4'h0, 32'h0, TIMEOUT, 1'b1);
    txn(32'h0400_0000, 4'h0, 32'h0, TIMEOUT - 1, 1'b1);
    txn(32'h0600_0004, 4'h3, 32'h1234_ABCD, 0, 1'b1);

    // Reset in the middle of an access drops it asynchronously.
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0000;
    bus.iomem_wstrb = 4'hC;
    bus.iomem_wdata = 32'h5555_AAAA;
    bus.slv_ready   = '0;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("mid rst iomem_ready", {31'b0, bus.iomem_ready}, 32'd0);
    check("mid rst iomem_rdata", bus.iomem_rdata, 32'd0);
    check("mid rst slv_valid", 32'(bus.slv_valid), 32'd0);
    check("mid rst slv_addr", bus.slv_addr, 32'd0);
    check("mid rst slv_wstrb", {28'b0, bus.slv_wstrb}, 32'd0);
    check("mid rst slv_wdata", bus.slv_wdata, 32'd0);
    check("mid rst err_irq", {31'b0, err_irq}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    txn(32'h0400_0000, 4'h0, 32'h0, 2, 1'b1);

    for (int unsigned n = 0; n < 80; n++) begin
      logic [7:0] page;
      if ($urandom_range(0, 7) == 0) page = 8'($urandom);
      else page = BASE_PAGE - 8'd1 + 8'($urandom_range(0, NSLOTS + 1));
      txn({page, 24'($urandom)}, 4'($urandom), $urandom,
          $urandom_range(0, 11), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
